// File: rtl/l8_psum_writeback.sv
// Read-modify-write accumulator in front of the layer-8 BRAM2 bank: each accepted
// partial-sum vector is added lane-wise (saturating) to the stored vector at addr_cnt.
module l8_psum_writeback #(
    parameter int N_adder_tree = 16,
    parameter int addr_width   = 10,
    parameter int DEPTH        = 1024,
    parameter int N_PASS       = 4,
    parameter int RELU         = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_adder_tree*16-1:0]   in_data,
    output logic [addr_width-1:0]        BRAM2_addr,
    output logic                         wr,
    output logic [N_adder_tree*16-1:0]   BRAM2_in,
    input  logic [N_adder_tree*16-1:0]   BRAM2_out,
    output logic                         busy,
    output logic                         done
);

    localparam int VEC_W  = N_adder_tree * 16;
    localparam int PASS_W = $clog2(N_PASS + 1);

    typedef enum logic [2:0] {IDLE, RD, ADD, WR, FIN} state_t;

    state_t                 state;
    logic [addr_width-1:0]  addr_cnt;
    logic [PASS_W-1:0]      pass_cnt;
    logic [VEC_W-1:0]       in_data_p0;
    logic [VEC_W-1:0]       sum_p0;
    logic                   first_pass;
    logic                   last_pass;
    logic                   last_addr;

    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        if (v > 17'sd32767)
            return 16'sh7FFF;
        else if (v < -17'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    function automatic logic signed [15:0] relu16(input logic signed [15:0] v);
        return v[15] ? 16'sd0 : v;
    endfunction

    assign first_pass = (pass_cnt == '0);
    assign last_pass  = (pass_cnt == PASS_W'(N_PASS - 1));
    assign last_addr  = (addr_cnt == addr_width'(DEPTH - 1));

    // Stage p0: operand captured at accept; BRAM2_out for the same address is valid during ADD.
    always_ff @(posedge clk) begin
        if (state == RD && in_valid && in_ready)
            in_data_p0 <= in_data;
    end

    always_comb begin
        logic signed [15:0] lane_in;
        logic signed [15:0] lane_old;
        logic signed [16:0] lane_wide;
        logic signed [15:0] lane_sum;
        sum_p0    = '0;
        lane_in   = '0;
        lane_old  = '0;
        lane_wide = '0;
        lane_sum  = '0;
        for (int i = 0; i < N_adder_tree; i++) begin
            lane_in   = in_data_p0[16*i +: 16];
            // Stale bank contents are never cleared, so the first pass ignores them.
            lane_old  = first_pass ? 16'sd0 : BRAM2_out[16*i +: 16];
            lane_wide = {lane_in[15], lane_in} + {lane_old[15], lane_old};
            lane_sum  = sat16(lane_wide);
            if (RELU != 0 && last_pass)
                lane_sum = relu16(lane_sum);
            sum_p0[16*i +: 16] = lane_sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_cnt   <= '0;
            pass_cnt   <= '0;
            in_ready   <= 1'b0;
            wr         <= 1'b0;
            BRAM2_addr <= '0;
            BRAM2_in   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        addr_cnt   <= '0;
                        pass_cnt   <= '0;
                        busy       <= 1'b1;
                        in_ready   <= 1'b1;
                        BRAM2_addr <= '0;
                        state      <= RD;
                    end
                end
                RD: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        state    <= ADD;
                    end
                end
                ADD: begin
                    wr         <= 1'b1;
                    BRAM2_addr <= addr_cnt;
                    BRAM2_in   <= sum_p0;
                    state      <= WR;
                end
                WR: begin
                    wr <= 1'b0;
                    if (last_addr) begin
                        addr_cnt <= '0;
                        pass_cnt <= pass_cnt + 1'b1;
                    end else begin
                        addr_cnt <= addr_cnt + 1'b1;
                    end
                    if (last_addr && last_pass) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end else begin
                        in_ready   <= 1'b1;
                        BRAM2_addr <= last_addr ? '0 : addr_cnt + 1'b1;
                        state      <= RD;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l8_psum_writeback.sv
// Directed bench for l8_psum_writeback: four instances with different DEPTH/N_PASS/RELU,
// each with its own behavioural BRAM2 bank (1-cycle read latency).
module tb_l8_psum_writeback;

    localparam int NL = 4;
    localparam int VW = NL * 16;
    localparam logic [VW-1:0] STALE = 64'h7abc_8123_0fff_f001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    start = '0;
    logic          in_valid = 1'b0;
    logic [VW-1:0] in_data = '0;
    logic          load_stale = 1'b0;

    logic [3:0]    in_ready_v, wr_v, busy_v, done_v;
    logic [9:0]    addr [4];
    logic [VW-1:0] bin  [4];
    logic [VW-1:0] bout [4];
    logic [VW-1:0] mem  [4][4];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // k=0: DEPTH4/N_PASS1/RELU1  k=1: DEPTH2/N_PASS3/RELU0  k=2: DEPTH2/N_PASS2/RELU1  k=3: DEPTH2/N_PASS2/RELU0
    l8_psum_writeback #(.N_adder_tree(NL), .addr_width(10), .DEPTH(4), .N_PASS(1), .RELU(1)) u_a (
        .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .in_data(in_data), .BRAM2_addr(addr[0]), .wr(wr_v[0]), .BRAM2_in(bin[0]),
        .BRAM2_out(bout[0]), .busy(busy_v[0]), .done(done_v[0]));
    l8_psum_writeback #(.N_adder_tree(NL), .addr_width(10), .DEPTH(2), .N_PASS(3), .RELU(0)) u_b (
        .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .in_data(in_data), .BRAM2_addr(addr[1]), .wr(wr_v[1]), .BRAM2_in(bin[1]),
        .BRAM2_out(bout[1]), .busy(busy_v[1]), .done(done_v[1]));
    l8_psum_writeback #(.N_adder_tree(NL), .addr_width(10), .DEPTH(2), .N_PASS(2), .RELU(1)) u_c (
        .clk(clk), .rst(rst), .start(start[2]), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .in_data(in_data), .BRAM2_addr(addr[2]), .wr(wr_v[2]), .BRAM2_in(bin[2]),
        .BRAM2_out(bout[2]), .busy(busy_v[2]), .done(done_v[2]));
    l8_psum_writeback #(.N_adder_tree(NL), .addr_width(10), .DEPTH(2), .N_PASS(2), .RELU(0)) u_d (
        .clk(clk), .rst(rst), .start(start[3]), .in_valid(in_valid), .in_ready(in_ready_v[3]),
        .in_data(in_data), .BRAM2_addr(addr[3]), .wr(wr_v[3]), .BRAM2_in(bin[3]),
        .BRAM2_out(bout[3]), .busy(busy_v[3]), .done(done_v[3]));

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (load_stale) begin
                for (int j = 0; j < 4; j++) mem[k][j] <= STALE;
            end else if (wr_v[k]) begin
                mem[k][addr[k][1:0]] <= bin[k];
            end
            bout[k] <= mem[k][addr[k][1:0]];
        end
    end

    function automatic logic [VW-1:0] vec4(input logic signed [15:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic stale_all();
        @(negedge clk); load_stale = 1'b1;
        @(negedge clk); load_stale = 1'b0;
    endtask

    task automatic pulse_start(input int k);
        @(negedge clk); start[k] = 1'b1;
        @(negedge clk); start[k] = 1'b0;
    endtask

    task automatic send(input int k, input logic [VW-1:0] d);
        bit ok;
        ok = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            if (in_ready_v[k]) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout inst=%0d in_ready never seen, required 1", k);
        end
    endtask

    task automatic wait_done(input int k);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            if (done_v[k]) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout inst=%0d done never seen, required 1", k);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if ({in_ready_v, wr_v, busy_v, done_v} !== 16'h0) begin
            n_err++; $display("FAIL reset_ctrl got %h required 0", {in_ready_v, wr_v, busy_v, done_v});
        end
        n_vec++;
        if (addr[0] !== 10'd0 || bin[0] !== '0) begin
            n_err++; $display("FAIL reset_data addr=%0d data=%h required 0/0", addr[0], bin[0]);
        end
        rst = 1'b0;
        pulse_start(0);
        send(0, vec4(9, 9, 9, 9));
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (wr_v[0] !== 1'b1) begin
            n_err++; $display("FAIL reset_pre_wr wr=%b required 1", wr_v[0]);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({wr_v[0], busy_v[0], done_v[0], in_ready_v[0]} !== 4'b0000) begin
            n_err++; $display("FAIL reset_async wr/busy/done/rdy=%b required 0000",
                              {wr_v[0], busy_v[0], done_v[0], in_ready_v[0]});
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy_v[0] !== 1'b0 || in_ready_v[0] !== 1'b0) begin
            n_err++; $display("FAIL reset_idle busy=%b rdy=%b required 0/0", busy_v[0], in_ready_v[0]);
        end
        pulse_start(0);
        n_vec++;
        if (in_ready_v[0] !== 1'b1 || addr[0] !== 10'd0 || busy_v[0] !== 1'b1) begin
            n_err++; $display("FAIL reset_restart rdy=%b addr=%0d busy=%b required 1/0/1",
                              in_ready_v[0], addr[0], busy_v[0]);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_single_pass();
        stale_all();
        pulse_start(0);
        for (int v = 5; v <= 8; v++) send(0, vec4(16'(v), 16'(v), 16'(v), 16'(v)));
        @(negedge clk);
        n_vec++;
        if (wr_v[0] !== 1'b0) begin
            n_err++; $display("FAIL sp_add_wr wr=%b required 0", wr_v[0]);
        end
        @(negedge clk);
        n_vec++;
        if (wr_v[0] !== 1'b1 || addr[0] !== 10'd3 || bin[0] !== vec4(8, 8, 8, 8)) begin
            n_err++; $display("FAIL sp_last_wr wr=%b addr=%0d data=%h required 1/3/%h",
                              wr_v[0], addr[0], bin[0], vec4(8, 8, 8, 8));
        end
        @(negedge clk);
        n_vec++;
        if (done_v[0] !== 1'b1 || wr_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
            n_err++; $display("FAIL sp_done done=%b wr=%b busy=%b required 1/0/0",
                              done_v[0], wr_v[0], busy_v[0]);
        end
        @(negedge clk);
        n_vec++;
        if (done_v[0] !== 1'b0) begin
            n_err++; $display("FAIL sp_done_width done=%b required 0", done_v[0]);
        end
        for (int a = 0; a < 4; a++) begin
            n_vec++;
            if (mem[0][a] !== vec4(16'(a + 5), 16'(a + 5), 16'(a + 5), 16'(a + 5))) begin
                n_err++; $display("FAIL sp_mem addr=%0d got %h required lanes=%0d", a, mem[0][a], a + 5);
            end
        end
    endtask

    task automatic test_multi_pass();
        stale_all();
        pulse_start(1);
        for (int i = 0; i < 6; i++) send(1, vec4(100, 100, -100, 1));
        wait_done(1);
        for (int a = 0; a < 2; a++) begin
            n_vec++;
            if (mem[1][a] !== vec4(300, 300, -300, 3)) begin
                n_err++; $display("FAIL mp_mem addr=%0d got %h required %h", a, mem[1][a], vec4(300, 300, -300, 3));
            end
        end
    endtask

    task automatic sat_stim(input int k);
        pulse_start(k);
        send(k, vec4(30000, -30000, -50, 5));
        send(k, vec4(32767, -32768, 100, -1));
        send(k, vec4(10000, -10000, 20, 6));
        send(k, vec4(1, -1, -200, -1));
        wait_done(k);
    endtask

    task automatic test_saturation();
        stale_all();
        sat_stim(3);
        n_vec++;
        if (mem[3][0] !== vec4(32767, -32768, -30, 11)) begin
            n_err++; $display("FAIL sat_addr0 got %h required %h", mem[3][0], vec4(32767, -32768, -30, 11));
        end
        n_vec++;
        if (mem[3][1] !== vec4(32767, -32768, -100, -2)) begin
            n_err++; $display("FAIL sat_addr1 got %h required %h", mem[3][1], vec4(32767, -32768, -100, -2));
        end
    endtask

    task automatic test_relu();
        stale_all();
        sat_stim(2);
        n_vec++;
        if (mem[2][0] !== vec4(32767, 0, 0, 11)) begin
            n_err++; $display("FAIL relu_addr0 got %h required %h", mem[2][0], vec4(32767, 0, 0, 11));
        end
        n_vec++;
        if (mem[2][1] !== vec4(32767, 0, 0, 0)) begin
            n_err++; $display("FAIL relu_addr1 got %h required %h", mem[2][1], vec4(32767, 0, 0, 0));
        end
    endtask

    task automatic test_backpressure();
        bit rdy;
        stale_all();
        pulse_start(1);
        send(1, vec4(7, -7, 0, 32767));
        rdy = 1'b0;
        for (int t = 0; t < 10 && !rdy; t++) begin
            @(negedge clk);
            if (in_ready_v[1]) rdy = 1'b1;
        end
        n_vec++;
        if (!rdy) begin
            n_err++; $display("FAIL bp_rd_reentry in_ready=0 required 1");
        end
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if (in_ready_v[1] !== 1'b1 || wr_v[1] !== 1'b0 || addr[1] !== 10'd1 || busy_v[1] !== 1'b1) begin
                n_err++; $display("FAIL bp_hold cyc=%0d rdy=%b wr=%b addr=%0d busy=%b required 1/0/1/1",
                                  c, in_ready_v[1], wr_v[1], addr[1], busy_v[1]);
            end
            start[1] = (c == 2);
            @(negedge clk);
        end
        start[1] = 1'b0;
        for (int i = 0; i < 5; i++) send(1, vec4(7, -7, 0, 32767));
        wait_done(1);
        for (int a = 0; a < 2; a++) begin
            n_vec++;
            if (mem[1][a] !== vec4(21, -21, 0, 32767)) begin
                n_err++; $display("FAIL bp_mem addr=%0d got %h required %h", a, mem[1][a], vec4(21, -21, 0, 32767));
            end
        end
    endtask

    task automatic test_back_to_back();
        int idx, last, cyc;
        bit fin;
        idx = 0; last = -1; cyc = 0; fin = 1'b0;
        pulse_start(0);
        in_data  = vec4(1, 1, 1, 1);
        in_valid = 1'b1;
        for (int t = 0; t < 60 && !fin; t++) begin
            @(negedge clk);
            cyc++;
            if (wr_v[0]) begin
                n_vec++;
                if (bin[0] !== vec4(16'(idx + 1), 16'(idx + 1), 16'(idx + 1), 16'(idx + 1)) || addr[0] !== 10'(idx)) begin
                    n_err++; $display("FAIL b2b_wr idx=%0d addr=%0d data=%h required addr=%0d lanes=%0d",
                                      idx, addr[0], bin[0], idx, idx + 1);
                end
                if (last >= 0) begin
                    n_vec++;
                    if (cyc - last != 3) begin
                        n_err++; $display("FAIL b2b_spacing idx=%0d got %0d cycles required 3", idx, cyc - last);
                    end
                end
                last = cyc;
                idx++;
                in_data = vec4(16'(idx + 1), 16'(idx + 1), 16'(idx + 1), 16'(idx + 1));
            end
            if (done_v[0]) begin
                fin = 1'b1;
                start[0] = 1'b1;
            end
        end
        n_vec++;
        if (!fin || idx != 4) begin
            n_err++; $display("FAIL b2b_count writes=%0d done=%b required 4/1", idx, fin);
        end
        @(negedge clk);
        start[0] = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if (busy_v[0] !== 1'b0 || in_ready_v[0] !== 1'b0) begin
            n_err++; $display("FAIL b2b_fin_start busy=%b rdy=%b required 0/0", busy_v[0], in_ready_v[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_multi_pass();
        test_saturation();
        test_relu();
        test_backpressure();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
